// File: rtl/op2_shifter_pkg.sv
// Shared types and helpers for the operand-2 shifter stage.
package op2_shifter_pkg;

   localparam int unsigned WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } sh_type_e;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_REGSH = 1'b1
   } state_e;

   // Rotated-immediate amount is twice the 4-bit rotate field.
   function automatic logic [7:0] imm_rot_amount(input logic [3:0] rot);
      return {3'b000, rot, 1'b0};
   endfunction

endpackage

// File: rtl/op2_shifter_if.sv
// Upstream operand and downstream result handshake bundle for op2_shifter.
interface op2_shifter_if
   import op2_shifter_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_WIDTH
);

   logic             in_Valid;
   logic             out_Ready;
   logic             in_IsImm;
   logic [7:0]       in_Imm8;
   logic [3:0]       in_Rot;
   logic [WIDTH-1:0] in_Rm;
   logic [1:0]       in_ShType;
   logic             in_ShByReg;
   logic [4:0]       in_ShAmt;
   logic [7:0]       in_Rs;
   logic             in_Carry;
   logic             out_Valid;
   logic             in_Ready;
   logic [WIDTH-1:0] out_Op2;
   logic             out_ShCarry;

   modport slave (
      input  in_Valid, in_IsImm, in_Imm8, in_Rot, in_Rm, in_ShType,
             in_ShByReg, in_ShAmt, in_Rs, in_Carry, in_Ready,
      output out_Ready, out_Valid, out_Op2, out_ShCarry
   );

   modport master (
      output in_Valid, in_IsImm, in_Imm8, in_Rot, in_Rm, in_ShType,
             in_ShByReg, in_ShAmt, in_Rs, in_Carry, in_Ready,
      input  out_Ready, out_Valid, out_Op2, out_ShCarry
   );

endinterface

// File: rtl/op2_shifter_barrel_shift_core.sv
// Combinational barrel shifter: LSL/LSR/ASR/ROR/RRX with shifter carry-out,
// immediate-amount (#0 aliases) and register-amount (0..255) semantics.
module barrel_shift_core
   import op2_shifter_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_WIDTH
) (
   input  logic [WIDTH-1:0] value,
   input  logic [7:0]       amount,
   input  sh_type_e         sh_type,
   input  logic             by_reg,
   input  logic             carry_in,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
);

   localparam int unsigned SW        = $clog2(WIDTH);
   localparam logic [7:0]  WIDTH_AMT = 8'(WIDTH);

   logic [7:0]       n;
   logic             rrx;
   logic [SW-1:0]    r;
   logic [SW-1:0]    rl;
   logic [WIDTH:0]   lsl_ext;
   logic [WIDTH:0]   rsh_ext;

   always_comb begin
      n         = amount;
      rrx       = 1'b0;
      result    = value;
      carry_out = carry_in;
      lsl_ext   = '0;
      rsh_ext   = '0;

      // Immediate amount #0 is folded into register semantics: LSR/ASR #0 become #32, ROR #0 becomes RRX.
      if (!by_reg) begin
         n = {3'b000, amount[4:0]};
         if (amount[4:0] == 5'd0) begin
            case (sh_type)
               SH_LSR, SH_ASR: n   = WIDTH_AMT;
               SH_ROR:         rrx = 1'b1;
               default:        n   = '0;
            endcase
         end
      end

      r  = n[SW-1:0];
      rl = -r;

      if (rrx) begin
         result    = {carry_in, value[WIDTH-1:1]};
         carry_out = value[0];
      end else if (n != '0) begin
         case (sh_type)
            SH_LSL: begin
               if (n < WIDTH_AMT) begin
                  lsl_ext   = {1'b0, value} << r;
                  result    = lsl_ext[WIDTH-1:0];
                  carry_out = lsl_ext[WIDTH];
               end else begin
                  result    = '0;
                  carry_out = (n == WIDTH_AMT) ? value[0] : 1'b0;
               end
            end
            SH_LSR: begin
               if (n < WIDTH_AMT) begin
                  rsh_ext   = {value, 1'b0} >> r;
                  result    = rsh_ext[WIDTH:1];
                  carry_out = rsh_ext[0];
               end else begin
                  result    = '0;
                  carry_out = (n == WIDTH_AMT) ? value[WIDTH-1] : 1'b0;
               end
            end
            SH_ASR: begin
               if (n < WIDTH_AMT) begin
                  rsh_ext   = $signed({value, 1'b0}) >>> r;
                  result    = rsh_ext[WIDTH:1];
                  carry_out = rsh_ext[0];
               end else begin
                  result    = {WIDTH{value[WIDTH-1]}};
                  carry_out = value[WIDTH-1];
               end
            end
            default: begin
               if (r == '0) begin
                  result    = value;
                  carry_out = value[WIDTH-1];
               end else begin
                  result    = (value >> r) | (value << rl);
                  carry_out = result[WIDTH-1];
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/op2_shifter.sv
// Registered operand-2 stage: rotated immediate or shifted Rm plus shifter carry, behind a valid/ready register.
// Build option OP2_REG_SHIFT_EN: register-amount shifts take an extra S_REGSH cycle; otherwise in_ShByReg is ignored.
module op2_shifter
   import op2_shifter_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_WIDTH
) (
   input logic          in_Clk,
   input logic          in_Rst_N,
   op2_shifter_if.slave bus
);

   state_e           state_q, state_d;
   logic             out_valid_q;
   logic [WIDTH-1:0] op2_q;
   logic             carry_q;

   logic [WIDTH-1:0] rm_q;
   logic [7:0]       rs_q;
   sh_type_e         sh_type_q;
   logic             carry_in_q;

   logic             out_free, ready, accept, drain, reg_op, load;
   logic [WIDTH-1:0] core_value, core_result;
   logic [7:0]       core_amount;
   sh_type_e         core_type;
   logic             core_by_reg, core_carry_in, core_carry_out;

`ifdef OP2_REG_SHIFT_EN
   assign reg_op = bus.in_ShByReg && !bus.in_IsImm;
`else
   logic unused_sh_by_reg;
   assign unused_sh_by_reg = bus.in_ShByReg;
   assign reg_op           = 1'b0;
`endif

   assign out_free = !out_valid_q || bus.in_Ready;
   assign ready    = (state_q == S_IDLE) && out_free;
   assign accept   = bus.in_Valid && ready;
   assign drain    = out_valid_q && bus.in_Ready;

   // The immediate form reuses the core as a register-amount ROR by 2*rot, which yields C=in_Carry for rot==0.
   always_comb begin
      state_d       = state_q;
      load          = 1'b0;
      core_value    = bus.in_Rm;
      core_amount   = {3'b000, bus.in_ShAmt};
      core_type     = sh_type_e'(bus.in_ShType);
      core_by_reg   = 1'b0;
      core_carry_in = bus.in_Carry;

      case (state_q)
         S_IDLE: begin
            if (bus.in_IsImm) begin
               core_value  = WIDTH'(bus.in_Imm8);
               core_amount = imm_rot_amount(bus.in_Rot);
               core_type   = SH_ROR;
               core_by_reg = 1'b1;
            end
            if (accept) begin
               if (reg_op) state_d = S_REGSH;
               else        load    = 1'b1;
            end
         end
         S_REGSH: begin
            core_value    = rm_q;
            core_amount   = rs_q;
            core_type     = sh_type_q;
            core_by_reg   = 1'b1;
            core_carry_in = carry_in_q;
            if (out_free) begin
               load    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   barrel_shift_core #(.WIDTH(WIDTH)) u_core (
      .value     (core_value),
      .amount    (core_amount),
      .sh_type   (core_type),
      .by_reg    (core_by_reg),
      .carry_in  (core_carry_in),
      .result    (core_result),
      .carry_out (core_carry_out)
   );

   always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      if (!in_Rst_N) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         op2_q       <= '0;
         carry_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            out_valid_q <= 1'b1;
            op2_q       <= core_result;
            carry_q     <= core_carry_out;
         end else if (drain) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      if (!in_Rst_N) begin
         rm_q       <= '0;
         rs_q       <= '0;
         sh_type_q  <= SH_LSL;
         carry_in_q <= 1'b0;
      end else if (accept && reg_op) begin
         rm_q       <= bus.in_Rm;
         rs_q       <= bus.in_Rs;
         sh_type_q  <= sh_type_e'(bus.in_ShType);
         carry_in_q <= bus.in_Carry;
      end
   end

   assign bus.out_Ready   = ready;
   assign bus.out_Valid   = out_valid_q;
   assign bus.out_Op2     = op2_q;
   assign bus.out_ShCarry = carry_q;

endmodule

// File: tb/tb_op2_shifter.sv
// Scoreboard bench for op2_shifter; expected results come from a bit-loop reference model.
module tb_op2_shifter;

`ifdef OP2_REG_SHIFT_EN
   localparam bit REG_SHIFT_ON = 1'b1;
   localparam int SPACING      = 20;
`else
   localparam bit REG_SHIFT_ON = 1'b0;
   localparam int SPACING      = 10;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [32:0] sb[$];
   bit   rand_done;

   always #5 clk = ~clk;

   op2_shifter_if #(.WIDTH(32)) bus ();

   op2_shifter #(.WIDTH(32)) dut (
      .in_Clk   (clk),
      .in_Rst_N (rst_n),
      .bus      (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [32:0] model(input logic is_imm, input logic [7:0] imm8, input logic [3:0] rot,
                                         input logic [31:0] rm, input logic [1:0] t, input logic by_reg,
                                         input logic [4:0] shamt, input logic [7:0] rs, input logic cin);
      logic [31:0] iv, r;
      logic        c;
      int          n, k;
      iv = {24'h0, imm8};
      r  = rm;
      c  = cin;
      if (is_imm) begin
         n = 2 * int'(rot);
         for (int i = 0; i < 32; i++) r[i] = iv[(i + n) % 32];
         c = (rot == 4'd0) ? cin : r[31];
         return {c, r};
      end
      if (by_reg && REG_SHIFT_ON) begin
         n = int'(rs);
      end else begin
         n = int'(shamt);
         if (n == 0) begin
            if (t == 2'b01 || t == 2'b10) n = 32;
            else if (t == 2'b11) return {rm[0], cin, rm[31:1]};
         end
      end
      if (n == 0) return {cin, rm};
      case (t)
         2'b00: begin
            for (int i = 0; i < 32; i++) r[i] = (i - n >= 0) ? rm[i - n] : 1'b0;
            c = (n <= 32) ? rm[32 - n] : 1'b0;
         end
         2'b01: begin
            for (int i = 0; i < 32; i++) r[i] = (i + n < 32) ? rm[i + n] : 1'b0;
            c = (n <= 32) ? rm[n - 1] : 1'b0;
         end
         2'b10: begin
            for (int i = 0; i < 32; i++) r[i] = (i + n < 32) ? rm[i + n] : rm[31];
            c = (n <= 32) ? rm[n - 1] : rm[31];
         end
         default: begin
            k = n % 32;
            if (k == 0) begin
               r = rm;
               c = rm[31];
            end else begin
               for (int i = 0; i < 32; i++) r[i] = rm[(i + k) % 32];
               c = rm[k - 1];
            end
         end
      endcase
      return {c, r};
   endfunction

   // Transfers are decided by values that are stable from posedge+1 until the next posedge.
   always @(negedge clk) begin : monitor
      logic [32:0] e;
      if (rst_n) begin
         if (bus.out_Valid && bus.in_Ready) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("sb_op2", bus.out_Op2, e[31:0]);
               check("sb_carry", 32'(bus.out_ShCarry), 32'(e[32]));
            end
         end
         if (bus.in_Valid && bus.out_Ready)
            sb.push_back(model(bus.in_IsImm, bus.in_Imm8, bus.in_Rot, bus.in_Rm, bus.in_ShType,
                               bus.in_ShByReg, bus.in_ShAmt, bus.in_Rs, bus.in_Carry));
      end
   end

   task automatic send(input logic is_imm, input logic [7:0] imm8, input logic [3:0] rot,
                       input logic [31:0] rm, input logic [1:0] t, input logic by_reg,
                       input logic [4:0] shamt, input logic [7:0] rs, input logic cin);
      int k;
      bus.in_IsImm   = is_imm;
      bus.in_Imm8    = imm8;
      bus.in_Rot     = rot;
      bus.in_Rm      = rm;
      bus.in_ShType  = t;
      bus.in_ShByReg = by_reg;
      bus.in_ShAmt   = shamt;
      bus.in_Rs      = rs;
      bus.in_Carry   = cin;
      bus.in_Valid   = 1'b1;
      for (k = 0; k < 64; k++) begin
         @(negedge clk);
         if (bus.out_Ready) break;
      end
      if (k == 64) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bus.in_Valid = 1'b0;
   endtask

   task automatic send_imm(input logic [7:0] imm8, input logic [3:0] rot, input logic cin);
      send(1'b1, imm8, rot, 32'h0, 2'b00, 1'b0, 5'd0, 8'd0, cin);
   endtask

   task automatic send_sh(input logic [31:0] rm, input logic [1:0] t, input logic by_reg,
                          input logic [4:0] shamt, input logic [7:0] rs, input logic cin);
      send(1'b0, 8'h0, 4'h0, rm, t, by_reg, shamt, rs, cin);
   endtask

   function automatic logic [7:0] rs_pick();
      case ($urandom_range(0, 7))
         0: return 8'd0;
         1: return 8'd1;
         2: return 8'd31;
         3: return 8'd32;
         4: return 8'd33;
         5: return 8'd64;
         6: return 8'd255;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]  t3_type [4] = '{2'b00, 2'b00, 2'b11, 2'b00};
      logic [7:0]  t3_rs   [4] = '{8'd32, 8'd33, 8'd64, 8'd0};
      logic        t3_cin  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] t3_op2  [4] = '{32'h0, 32'h0, 32'h1, 32'h1};
      logic        t3_c    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      time         t0, t1;
      int          k;

      bus.in_Valid = 1'b0; bus.in_IsImm = 1'b0; bus.in_Imm8 = '0; bus.in_Rot = '0;
      bus.in_Rm = '0; bus.in_ShType = '0; bus.in_ShByReg = 1'b0; bus.in_ShAmt = '0;
      bus.in_Rs = '0; bus.in_Carry = 1'b0; bus.in_Ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.out_Valid), 32'd0);
      check("rst_op2", bus.out_Op2, 32'h0);
      check("rst_carry", 32'(bus.out_ShCarry), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.out_Ready), 32'd1);

      // Rotated immediate, one-cycle latency
      send_imm(8'hFF, 4'd4, 1'b0);
      check("t1_valid_lat", 32'(bus.out_Valid), 32'd1);
      check("t1_op2", bus.out_Op2, 32'hFF000000);
      check("t1_carry", 32'(bus.out_ShCarry), 32'd1);

      // Immediate-amount #0 aliases
      send_sh(32'h80000001, 2'b00, 1'b0, 5'd0, 8'd0, 1'b1);
      check("t2_lsl0", bus.out_Op2, 32'h80000001);
      check("t2_lsl0_c", 32'(bus.out_ShCarry), 32'd1);
      send_sh(32'h80000001, 2'b01, 1'b0, 5'd0, 8'd0, 1'b0);
      check("t2_lsr0", bus.out_Op2, 32'h0);
      check("t2_lsr0_c", 32'(bus.out_ShCarry), 32'd1);
      send_sh(32'h80000001, 2'b10, 1'b0, 5'd0, 8'd0, 1'b0);
      check("t2_asr0", bus.out_Op2, 32'hFFFFFFFF);
      check("t2_asr0_c", 32'(bus.out_ShCarry), 32'd1);
      send_sh(32'h80000001, 2'b11, 1'b0, 5'd0, 8'd0, 1'b0);
      check("t2_rrx", bus.out_Op2, 32'h40000000);
      check("t2_rrx_c", 32'(bus.out_ShCarry), 32'd1);

      // Register-amount boundaries
      for (int i = 0; i < 4; i++) begin
         send_sh(32'h00000001, t3_type[i], 1'b1, 5'd0, t3_rs[i], t3_cin[i]);
         if (REG_SHIFT_ON) begin
            @(posedge clk);
            #1;
            check("t3_op2", bus.out_Op2, t3_op2[i]);
            check("t3_carry", 32'(bus.out_ShCarry), 32'(t3_c[i]));
         end
      end
      repeat (2) @(posedge clk);
      #1;

      // Back-pressure: held result is stable, then accept and drain on the same edge
      bus.in_Ready = 1'b0;
      send_imm(8'h03, 4'd1, 1'b0);
      check("t4_valid", 32'(bus.out_Valid), 32'd1);
      bus.in_IsImm = 1'b1; bus.in_Imm8 = 8'h81; bus.in_Rot = 4'd0; bus.in_Carry = 1'b1;
      bus.in_Valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_hold_op2", bus.out_Op2, 32'hC0000000);
         check("t4_hold_valid", 32'(bus.out_Valid), 32'd1);
         check("t4_hold_ready", 32'(bus.out_Ready), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.in_Ready = 1'b1;
      @(negedge clk);
      check("t4_acc_drain_ready", 32'(bus.out_Ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_Valid = 1'b0;
      check("t4_no_bubble", 32'(bus.out_Valid), 32'd1);
      check("t4_next_op2", bus.out_Op2, 32'h00000081);

      // Back-to-back register shifts
      send_sh(32'h0000F000, 2'b01, 1'b1, 5'd3, 8'd4, 1'b0);
      t0 = $time;
      send_sh(32'h0000F000, 2'b00, 1'b1, 5'd3, 8'd4, 1'b0);
      t1 = $time;
      check("t5_spacing", 32'(t1 - t0), 32'(SPACING));
      repeat (3) @(posedge clk);
      #1;

      // Asynchronous reset with a held result
      bus.in_Ready = 1'b0;
      send_imm(8'h03, 4'd1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", 32'(bus.out_Valid), 32'd0);
      check("t6_async_op2", bus.out_Op2, 32'h0);
      check("t6_async_carry", 32'(bus.out_ShCarry), 32'd0);
      sb.delete();
      #2;
      rst_n = 1'b1;
      bus.in_Ready = 1'b1;
      @(posedge clk);
      #1;
      check("t6_post_ready", 32'(bus.out_Ready), 32'd1);

      if (REG_SHIFT_ON) begin
         send_sh(32'h00000001, 2'b00, 1'b1, 5'd0, 8'd4, 1'b0);
         check("t6_in_regsh", 32'(bus.out_Ready), 32'd0);
         #2;
         rst_n = 1'b0;
         #1;
         check("t6_regsh_valid", 32'(bus.out_Valid), 32'd0);
         check("t6_regsh_op2", bus.out_Op2, 32'h0);
         sb.delete();
         #2;
         rst_n = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_stale", 32'(bus.out_Valid), 32'd0);
            check("t6_idle_ready", 32'(bus.out_Ready), 32'd1);
         end
         @(posedge clk);
         #1;
      end

      // Random operands with random back-pressure
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               if ($urandom_range(0, 3) == 0)
                  send_imm(8'($urandom), 4'($urandom), 1'($urandom));
               else
                  send_sh(32'($urandom), 2'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), rs_pick(), 1'($urandom));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               bus.in_Ready = 1'($urandom);
            end
         end
      join
      bus.in_Ready = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      check("sb_drain", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
